demux_4x1_rx: RTL
=================

Name: demux_4x1_rx

Overview:
- Receive-side counterpart of the 4:1 byte mux in phy_tx.
- Takes the serialized byte stream (data_000/valid_000), one byte per clk_4f cycle in lane order 0,1,2,3, and rebuilds the four 8-bit lanes with their valid bits.
- Presents one complete lane frame every 4 cycles, with a 1-cycle strobe.
- Sits at the head of phy_rx logic, feeding the per-lane paths.

Parameters:
- DATA_W, 8, byte width of every lane and of the serial input.
- IDLE_FRAMES, 2, consecutive all-invalid frames in RUN before dropping back to IDLE (range 1..15).

Ports:
- clk_4f  input  1  single clock, serial byte rate (4x frame rate).
- reset_L  input  1  asynchronous, active-low reset.
- data_000  input  DATA_W  serialized byte.
- valid_000  input  1  byte-valid qualifier for data_000.
- data_0  output  DATA_W  lane 0 byte of last completed frame.
- data_1  output  DATA_W  lane 1 byte of last completed frame.
- data_2  output  DATA_W  lane 2 byte of last completed frame.
- data_3  output  DATA_W  lane 3 byte of last completed frame.
- valid_0..valid_3  output  1 each  per-lane valid of last completed frame.
- frame_stb  output  1  1-cycle pulse: data_x/valid_x updated this cycle.
- locked  output  1  high while FSM in RUN.

Behaviour:
- Reset (reset_L=0, async): all outputs 0, FSM=IDLE, slot counter=0, staging regs=0, idle-frame counter=0. Release is synchronous to the next clk_4f edge.
- FSM states:
  - IDLE: waits for the first valid_000=1. That byte is lane 0: it is captured into stage0, slot becomes 1 and the FSM moves to RUN. locked=1 from the following cycle.
  - RUN: 2-bit slot counter increments every cycle and wraps 3->0. Slots 0..2 capture into stage0..2; slot 3 is the frame-complete slot.
- Capture rule: on valid_000=1, store data_000 with valid=1. On valid_000=0, store data 0 with valid=0 (the captured byte is ignored).
- Frame complete (slot 3): stage0..2 plus the current byte/valid are registered into data_0..3/valid_0..3, and frame_stb=1 for exactly one cycle. Outputs hold until the next frame completes.
- Latency: lane-3 byte sampled at edge t; outputs and frame_stb visible after edge t+1 (1 cycle). Lane-0 byte to output: 4 cycles.
- Idle detect:
  - A frame whose 4 valids are all 0 increments the idle-frame counter; any frame with a valid resets it to 0.
  - When the counter reaches IDLE_FRAMES, the FSM goes to IDLE and the counter clears. The all-invalid frame is still emitted with frame_stb=1.
  - No frame_stb is produced while in IDLE.
- Back-to-back: a byte with valid_000=1 on the same cycle as the transition to IDLE is not taken as lane 0. Lane-0 detection restarts on the next cycle.
- Reset mid-frame: the partial frame is discarded, outputs clear to 0 immediately, and no strobe is issued.
- Lane order is fixed; there is no realignment in RUN except by going through IDLE.

Optional Feature:
- Macro: DEMUX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments by 1 on every RUN slot with valid_000=0 that is not part of an all-invalid frame, i.e. a partial frame; the count is applied at slot 3.
  - Saturates at 8'hFF and clears only on reset.
- When undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package phy_pkg:
  - DATA_W default and LANES=4 constants.
  - Slot index typedef (2-bit).
  - FSM state enum {IDLE, RUN}.
- Sub-module lane_stage: one DATA_W+1 register with capture enable and zero-on-invalid rule. It is instantiated 3 times for stage0..2. The output register bank stays in the top.

Test Plan:
- Reset then idle: reset_L low 3 cycles, valid_000=0 for 20 cycles -> all outputs 0, locked=0, no frame_stb.
- Full frame: bytes 8'hA0,8'hA1,8'hA2,8'hA3 with valid=1 on consecutive cycles -> one cycle after 8'hA3: data_0..3=A0..A3, valid_0..3=1, frame_stb=1 for 1 cycle, locked=1.
- Partial frame: frame 8'h10,(invalid 8'hFF),8'h12,8'h13 -> data_1=0, valid_1=0, other lanes valid with their values. With DEMUX_ERR_CNT_EN, err_cnt=1.
- Idle drop: after lock, 2 all-invalid frames (IDLE_FRAMES=2) -> two frame_stb pulses with valids 0, then locked=0. A following valid 8'h55 becomes the new data_0.
- Reset mid-frame: assert reset_L after lane-1 byte of frame 8'hC0..C3 -> outputs immediately 0, locked=0, no strobe. Next valid byte after release is lane 0.
- Continuous stream: 16 frames with incrementing bytes 8'h00..8'h3F -> frame_stb every 4th cycle, data_k = 4*n+k for frame n, no missed or duplicated strobes.

Source files
------------

// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared constants and types for the phy_rx lane demux
package phy_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int LANES      = 4;

   typedef logic [1:0] slot_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/lane_stage.sv
// rtl/lane_stage.sv - one staging register (byte + valid) for a lane slot
module lane_stage
   import phy_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_4f,
   input  logic              reset_L,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic [DATA_W-1:0] q_data,
   output logic              q_valid
);

   // An invalid byte is stored as zero so downstream never sees stale payload.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         q_data  <= '0;
         q_valid <= 1'b0;
      end else if (en) begin
         q_data  <= valid ? data : '0;
         q_valid <= valid;
      end
   end

endmodule

// File: rtl/demux_4x1_rx.sv
// rtl/demux_4x1_rx.sv - 1:4 byte demux rebuilding lane frames; DEMUX_ERR_CNT_EN adds err_cnt
module demux_4x1_rx
   import phy_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int IDLE_FRAMES = 2
) (
   input  logic              clk_4f,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_000,
   input  logic              valid_000,
   output logic [DATA_W-1:0] data_0,
   output logic [DATA_W-1:0] data_1,
   output logic [DATA_W-1:0] data_2,
   output logic [DATA_W-1:0] data_3,
   output logic              valid_0,
   output logic              valid_1,
   output logic              valid_2,
   output logic              valid_3,
   output logic              frame_stb,
   output logic              locked
`ifdef DEMUX_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam logic [3:0] IDLE_LAST = 4'(IDLE_FRAMES - 1);

   state_t            state;
   state_t            state_nxt;
   slot_t             slot;
   logic [3:0]        idle_cnt;
   logic [2:0]        st_en;
   logic [DATA_W-1:0] st_data  [3];
   logic              st_valid [3];
   logic [LANES-1:0]  frame_valid;
   logic              frame_done;
   logic              frame_idle;
   logic              idle_drop;

   for (genvar i = 0; i < 3; i++) begin : g_stage
      lane_stage #(.DATA_W(DATA_W)) u_stage (
         .clk_4f  (clk_4f),
         .reset_L (reset_L),
         .en      (st_en[i]),
         .data    (data_000),
         .valid   (valid_000),
         .q_data  (st_data[i]),
         .q_valid (st_valid[i])
      );
   end

   always_comb begin
      frame_done  = (state == RUN) && (slot == 2'd3);
      frame_valid = {valid_000, st_valid[2], st_valid[1], st_valid[0]};
      frame_idle  = ~|frame_valid;
      idle_drop   = frame_done && frame_idle && (idle_cnt == IDLE_LAST);
      // In IDLE the first valid byte is lane 0 and goes straight into stage0.
      st_en[0]    = ((state == IDLE) && valid_000) || ((state == RUN) && (slot == 2'd0));
      st_en[1]    = (state == RUN) && (slot == 2'd1);
      st_en[2]    = (state == RUN) && (slot == 2'd2);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid_000) state_nxt = RUN;
         RUN:     if (idle_drop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         slot      <= '0;
         idle_cnt  <= '0;
         frame_stb <= 1'b0;
         data_0    <= '0;
         data_1    <= '0;
         data_2    <= '0;
         data_3    <= '0;
         valid_0   <= 1'b0;
         valid_1   <= 1'b0;
         valid_2   <= 1'b0;
         valid_3   <= 1'b0;
      end else begin
         frame_stb <= frame_done;
         if (state == IDLE) slot <= valid_000 ? 2'd1 : 2'd0;
         else               slot <= slot + 2'd1;
         if (frame_done) begin
            data_0  <= st_data[0];
            data_1  <= st_data[1];
            data_2  <= st_data[2];
            data_3  <= valid_000 ? data_000 : '0;
            valid_0 <= st_valid[0];
            valid_1 <= st_valid[1];
            valid_2 <= st_valid[2];
            valid_3 <= valid_000;
            if (!frame_idle || idle_drop) idle_cnt <= '0;
            else                          idle_cnt <= idle_cnt + 4'd1;
         end
      end
   end

   assign locked = (state == RUN);

`ifdef DEMUX_ERR_CNT_EN
   logic [2:0] n_invalid;
   logic [8:0] err_sum;

   always_comb begin
      n_invalid = 3'(LANES) - 3'($countones(frame_valid));
      err_sum   = {1'b0, err_cnt} + {6'd0, n_invalid};
   end

   // All-invalid frames are idle fill, not errors; only partial frames count.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L)                      err_cnt <= '0;
      else if (frame_done && !frame_idle) err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
   end
`endif

endmodule
